// File: rtl/fpu_issue_pkg.sv
// Shared types and constants for the FPU issue controller.
// Opcode/state encodings, IEEE field constants and operand classification helpers.
package fpu_issue_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  localparam int FLAG_INVALID   = 0;
  localparam int FLAG_DIV_ZERO  = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 3;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
  endfunction

  // Denormals are deliberately not zero here; only +/-0 qualifies.
  function automatic logic fp_is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, EXP_MAX, 23'd0};
  endfunction

  function automatic logic [31:0] fp_zero(input logic sign);
    return {sign, 31'd0};
  endfunction

endpackage

// File: rtl/fpu_special_classify.sv
// Combinational screen for IEEE special operands (NaN, Inf, zero) the datapath cannot handle.
// Produces the final result and flags directly when the operation short-circuits.
module fpu_special_classify
  import fpu_issue_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] spec_res,
  output logic [3:0]  spec_flags
);

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic s_prod;
  logic b_sign_eff;

  assign a_nan      = fp_is_nan(a);
  assign b_nan      = fp_is_nan(b);
  assign a_inf      = fp_is_inf(a);
  assign b_inf      = fp_is_inf(b);
  assign a_zero     = fp_is_zero(a);
  assign b_zero     = fp_is_zero(b);
  assign s_prod     = a[31] ^ b[31];
  // Subtraction is addition of B with its sign flipped.
  assign b_sign_eff = b[31] ^ (op == OP_SUB);

  always_comb begin
    is_special = 1'b0;
    spec_res   = 32'd0;
    spec_flags = 4'd0;
    if (a_nan || b_nan) begin
      is_special               = 1'b1;
      spec_res                 = QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else begin
      case (op)
        OP_ADD, OP_SUB: begin
          if (a_inf && b_inf && (a[31] != b_sign_eff)) begin
            is_special               = 1'b1;
            spec_res                 = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
          end else if (a_inf) begin
            is_special = 1'b1;
            spec_res   = fp_inf(a[31]);
          end else if (b_inf) begin
            is_special = 1'b1;
            spec_res   = fp_inf(b_sign_eff);
          end
        end
        OP_MUL: begin
          if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            is_special               = 1'b1;
            spec_res                 = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
          end else if (a_inf || b_inf) begin
            is_special = 1'b1;
            spec_res   = fp_inf(s_prod);
          end
        end
        OP_DIV: begin
          if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            is_special               = 1'b1;
            spec_res                 = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
          end else if (b_zero && !a_inf) begin
            is_special                = 1'b1;
            spec_res                  = fp_inf(s_prod);
            spec_flags[FLAG_DIV_ZERO] = 1'b1;
          end else if (a_inf) begin
            is_special = 1'b1;
            spec_res   = fp_inf(s_prod);
          end else if (b_inf || a_zero) begin
            is_special = 1'b1;
            spec_res   = fp_zero(s_prod);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding issue controller for the combinational FPU: latches operands, waits a
// per-opcode settle window, returns result+tag+flags; in_ready only in IDLE, result held until out_ready.
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int ADD_CYCLES = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [3:0]  in_tag,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        dp_add_sub,
  input  logic [31:0] dp_add_res,
  input  logic [31:0] dp_mul_res,
  input  logic        dp_mul_ovf,
  input  logic        dp_mul_unf,
  input  logic [31:0] dp_div_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [3:0]  out_tag,
  output logic [3:0]  out_flags,
  output logic        busy
);

  localparam int MAX_AM  = (ADD_CYCLES > MUL_CYCLES) ? ADD_CYCLES : MUL_CYCLES;
  localparam int MAX_LAT = (MAX_AM > DIV_CYCLES) ? MAX_AM : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t ADD_LD = cnt_t'(ADD_CYCLES - 1);
  localparam cnt_t MUL_LD = cnt_t'(MUL_CYCLES - 1);
  localparam cnt_t DIV_LD = cnt_t'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  op_e         op_q, op_d;
  logic [31:0] dp_a_q, dp_a_d;
  logic [31:0] dp_b_q, dp_b_d;
  logic        dp_add_sub_q, dp_add_sub_d;
  logic [31:0] out_res_q, out_res_d;
  logic [3:0]  out_tag_q, out_tag_d;
  logic [3:0]  out_flags_q, out_flags_d;
  logic        out_valid_q, out_valid_d;

  op_e         in_op_e;
  logic        is_special;
  logic [31:0] spec_res;
  logic [3:0]  spec_flags;

  assign in_op_e = op_e'(in_op);

  fpu_special_classify u_classify (
    .op         (in_op_e),
    .a          (in_a),
    .b          (in_b),
    .is_special (is_special),
    .spec_res   (spec_res),
    .spec_flags (spec_flags)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_add_sub_d = dp_add_sub_q;
    out_res_d    = out_res_q;
    out_tag_d    = out_tag_q;
    out_flags_d  = out_flags_q;
    out_valid_d  = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dp_a_d       = in_a;
          dp_b_d       = in_b;
          op_d         = in_op_e;
          out_tag_d    = in_tag;
          dp_add_sub_d = (in_op_e != OP_SUB);
          if (is_special) begin
            out_res_d   = spec_res;
            out_flags_d = spec_flags;
            state_d     = DONE;
          end else begin
            case (in_op_e)
              OP_MUL:  cnt_d = MUL_LD;
              OP_DIV:  cnt_d = DIV_LD;
              default: cnt_d = ADD_LD;
            endcase
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == cnt_t'(0)) begin
          out_flags_d = 4'd0;
          case (op_q)
            OP_MUL: begin
              out_res_d                   = dp_mul_res;
              out_flags_d[FLAG_OVERFLOW]  = dp_mul_ovf;
              out_flags_d[FLAG_UNDERFLOW] = dp_mul_unf;
            end
            OP_DIV:  out_res_d = dp_div_res;
            default: out_res_d = dp_add_res;
          endcase
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      DONE: begin
        // Short-circuited results enter DONE with valid low and raise it one cycle later,
        // so every transaction takes at least one cycle after acceptance.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= OP_ADD;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      dp_add_sub_q <= 1'b0;
      out_res_q    <= '0;
      out_tag_q    <= '0;
      out_flags_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_add_sub_q <= dp_add_sub_d;
      out_res_q    <= out_res_d;
      out_tag_q    <= out_tag_d;
      out_flags_q  <= out_flags_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign dp_add_sub = dp_add_sub_q;
  assign out_valid  = out_valid_q;
  assign out_res    = out_res_q;
  assign out_tag    = out_tag_q;
  assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: latency, special-operand screening, backpressure and reset.
module tb_fpu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic        dp_add_sub;
  logic [31:0] dp_add_res;
  logic [31:0] dp_mul_res;
  logic        dp_mul_ovf;
  logic        dp_mul_unf;
  logic [31:0] dp_div_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;
  logic        busy;

  int tests = 0;
  int fails = 0;

  fpu_issue_ctrl #(.ADD_CYCLES(1), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_add_sub (dp_add_sub),
    .dp_add_res (dp_add_res),
    .dp_mul_res (dp_mul_res),
    .dp_mul_ovf (dp_mul_ovf),
    .dp_mul_unf (dp_mul_unf),
    .dp_div_res (dp_div_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_tag    (out_tag),
    .out_flags  (out_flags),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if ({dp_a, dp_b, dp_add_sub} !== 65'd0) begin fails++; $display("FAIL rst_dp: got %h %h %b want 0", dp_a, dp_b, dp_add_sub); end
    tests++; if ({out_res, out_tag, out_flags} !== 40'd0) begin fails++; $display("FAIL rst_out: got %h %h %h want 0", out_res, out_tag, out_flags); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add;
    out_ready  = 1'b1;
    dp_add_res = 32'h40400000;
    send(2'b00, 32'h3F800000, 32'h40000000, 4'd5);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_early_valid: got %b want 0", out_valid); end
    tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL add_busy: got busy=%b rdy=%b want 1/0", busy, in_ready); end
    tests++; if (dp_add_sub !== 1'b1) begin fails++; $display("FAIL add_dp_add_sub: got %b want 1", dp_add_sub); end
    tests++; if (dp_a !== 32'h3F800000 || dp_b !== 32'h40000000) begin fails++; $display("FAIL add_dp_ops: got %h %h want 3f800000 40000000", dp_a, dp_b); end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %b want 1", out_valid); end
    tests++; if (out_res !== 32'h40400000) begin fails++; $display("FAIL add_res: got %h want 40400000", out_res); end
    tests++; if (out_tag !== 4'd5 || out_flags !== 4'd0) begin fails++; $display("FAIL add_tag_flags: got %h %b want 5 0000", out_tag, out_flags); end
    tick();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL add_drain: got valid=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_sub_flag;
    out_ready  = 1'b1;
    dp_add_res = 32'h3F800000;
    send(2'b01, 32'h40000000, 32'h3F800000, 4'd6);
    tests++; if (dp_add_sub !== 1'b0) begin fails++; $display("FAIL sub_dp_add_sub: got %b want 0", dp_add_sub); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_res !== 32'h3F800000) begin fails++; $display("FAIL sub_res: got %b %h want 1 3f800000", out_valid, out_res); end
    tick();
  endtask

  task automatic test_div_latency;
    out_ready  = 1'b1;
    send(2'b11, 32'h40C00000, 32'h40000000, 4'd3);
    for (int i = 1; i <= 4; i++) begin
      dp_div_res = (i == 4) ? 32'h40400000 : 32'h40400000 + i;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL div_early_valid[%0d]: got %b want 0", i, out_valid); end
      tests++; if (dp_a !== 32'h40C00000 || dp_b !== 32'h40000000) begin fails++; $display("FAIL div_dp_stable[%0d]: got %h %h want 40c00000 40000000", i, dp_a, dp_b); end
      tick();
    end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL div_valid: got %b want 1", out_valid); end
    tests++; if (out_res !== 32'h40400000) begin fails++; $display("FAIL div_res: got %h want 40400000", out_res); end
    tests++; if (out_tag !== 4'd3 || out_flags !== 4'd0) begin fails++; $display("FAIL div_tag_flags: got %h %b want 3 0000", out_tag, out_flags); end
    tick();
  endtask

  task automatic test_special;
    logic [1:0]  s_op  [13] = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    logic [31:0] s_a   [13] = '{32'h3F800000, 32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h3F800000,
                                32'h3F800000, 32'h7F800001, 32'hC0000000, 32'h00000000, 32'hFF800000,
                                32'h3F800000, 32'h7F800000, 32'h00000001};
    logic [31:0] s_b   [13] = '{32'h00000000, 32'hFF800000, 32'h00000000, 32'h7F800000, 32'hFF800000,
                                32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h00000000, 32'h40000000,
                                32'hFF800000, 32'h80000000, 32'h00000000};
    logic [31:0] s_res [13] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                                32'hFF800000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'hFF800000,
                                32'h80000000, 32'hFF800000, 32'hDEADBEEF};
    logic [3:0]  s_flg [13] = '{4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001,
                                4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    out_ready  = 1'b1;
    dp_add_res = 32'hDEADBEEF;
    dp_mul_res = 32'hDEADBEEF;
    dp_mul_ovf = 1'b1;
    dp_div_res = 32'hDEADBEEF;
    for (int i = 0; i < 13; i++) begin
      send(s_op[i], s_a[i], s_b[i], 4'(i));
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL spec_early_valid[%0d]: got %b want 0", i, out_valid); end
      tick();
      tests++; if (out_valid !== 1'b1 || out_res !== s_res[i]) begin fails++; $display("FAIL spec_res[%0d]: got v=%b %h want 1 %h", i, out_valid, out_res, s_res[i]); end
      tests++; if (out_flags !== s_flg[i] || out_tag !== 4'(i)) begin fails++; $display("FAIL spec_flags[%0d]: got %b tag %h want %b tag %h", i, out_flags, out_tag, s_flg[i], 4'(i)); end
      tick();
    end
    dp_mul_ovf = 1'b0;
  endtask

  task automatic test_mul_flags;
    out_ready  = 1'b1;
    dp_mul_res = 32'h7F800000;
    dp_mul_ovf = 1'b1;
    dp_mul_unf = 1'b0;
    send(2'b10, 32'h7F000000, 32'h7F000000, 4'd8);
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mul_early_valid: got %b want 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_res !== 32'h7F800000) begin fails++; $display("FAIL mul_ovf_res: got %b %h want 1 7f800000", out_valid, out_res); end
    tests++; if (out_flags !== 4'b0100) begin fails++; $display("FAIL mul_ovf_flags: got %b want 0100", out_flags); end
    tick();
    dp_mul_ovf = 1'b0;
    dp_mul_unf = 1'b1;
    dp_mul_res = 32'h00000000;
    send(2'b10, 32'h00800000, 32'h00800000, 4'd9);
    tick();
    tick();
    tests++; if (out_valid !== 1'b1 || out_flags !== 4'b1000) begin fails++; $display("FAIL mul_unf_flags: got %b %b want 1 1000", out_valid, out_flags); end
    tick();
    dp_mul_unf = 1'b0;
  endtask

  task automatic test_back_to_back;
    out_ready  = 1'b0;
    dp_mul_res = 32'h40000000;
    send(2'b10, 32'h3F800000, 32'h40000000, 4'd7);
    in_op    = 2'b00;
    in_a     = 32'h40A00000;
    in_b     = 32'h3F800000;
    in_tag   = 4'd9;
    in_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++; if (out_valid !== 1'b1 || out_res !== 32'h40000000 || out_tag !== 4'd7) begin fails++; $display("FAIL bp_hold[%0d]: got %b %h %h want 1 40000000 7", i, out_valid, out_res, out_tag); end
      tests++; if (in_ready !== 1'b0 || dp_a !== 32'h3F800000) begin fails++; $display("FAIL bp_no_accept[%0d]: got rdy=%b dp_a=%h want 0 3f800000", i, in_ready, dp_a); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got rdy=%b valid=%b want 1/0", in_ready, out_valid); end
    tick();
    in_valid = 1'b0;
    tests++; if (busy !== 1'b1 || out_tag !== 4'd9 || dp_a !== 32'h40A00000) begin fails++; $display("FAIL bp_second_accept: got busy=%b tag=%h dp_a=%h want 1 9 40a00000", busy, out_tag, dp_a); end
    dp_add_res = 32'h40C00000;
    out_ready  = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b1 || out_res !== 32'h40C00000 || out_tag !== 4'd9) begin fails++; $display("FAIL bp_second_res: got %b %h %h want 1 40c00000 9", out_valid, out_res, out_tag); end
    tick();
  endtask

  task automatic test_reset_mid_exec;
    out_ready  = 1'b1;
    dp_div_res = 32'h3F000000;
    send(2'b11, 32'h3F800000, 32'h40000000, 4'd2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mrst_state: got busy=%b rdy=%b want 0/1", busy, in_ready); end
    tests++; if (dp_a !== 32'd0 || dp_b !== 32'd0 || out_tag !== 4'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL mrst_outputs: got %h %h %h %b want 0", dp_a, dp_b, out_tag, out_valid); end
    tick();
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_no_output: got %b want 0", out_valid); end
    rst_n = 1'b1;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mrst_ready: got %b want 1", in_ready); end
    dp_add_res = 32'h40800000;
    send(2'b00, 32'h40000000, 32'h40000000, 4'd4);
    tick();
    tests++; if (out_valid !== 1'b1 || out_res !== 32'h40800000 || out_tag !== 4'd4) begin fails++; $display("FAIL mrst_new_add: got %b %h %h want 1 40800000 4", out_valid, out_res, out_tag); end
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_op      = 2'b00;
    in_a       = 32'd0;
    in_b       = 32'd0;
    in_tag     = 4'd0;
    out_ready  = 1'b0;
    dp_add_res = 32'd0;
    dp_mul_res = 32'd0;
    dp_mul_ovf = 1'b0;
    dp_mul_unf = 1'b0;
    dp_div_res = 32'd0;
    test_reset();
    test_add();
    test_sub_flag();
    test_div_latency();
    test_special();
    test_mul_flags();
    test_back_to_back();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
